// File: rtl/io_gpio_pkg.sv
// Shared constants for the GPIO bank: default geometry and edge-event encoding.
package io_gpio_pkg;

  localparam int N_CH_DEF        = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_W_DEF      = 4;
  localparam int FILT_CYC_DEF    = 8;

  // Bit positions inside a per-channel edge-event vector
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_W    = 2;

  typedef logic [EDGE_W-1:0] edge_evt_t;

endpackage

// File: rtl/io_gpio_bank_if.sv
// Register-block side of the GPIO bank: drive controls, interrupt controls and status readback.
interface io_gpio_bank_if import io_gpio_pkg::*; #(
  parameter int N_CH = N_CH_DEF
) ();

  logic [N_CH-1:0] out_data;
  logic [N_CH-1:0] out_en;
  logic [N_CH-1:0] irq_rise_en;
  logic [N_CH-1:0] irq_fall_en;
  logic [N_CH-1:0] irq_clear;
  logic [N_CH-1:0] in_data;
  logic [N_CH-1:0] irq_pending;
  logic            irq;

  modport master (
    output out_data, out_en, irq_rise_en, irq_fall_en, irq_clear,
    input  in_data, irq_pending, irq
  );

  modport slave (
    input  out_data, out_en, irq_rise_en, irq_fall_en, irq_clear,
    output in_data, irq_pending, irq
  );

endinterface

// File: rtl/io_gpio_filter.sv
// One GPIO input channel: synchroniser chain, debounce counter, accepted level and
// one-cycle edge-event pulses aligned with the in_data update.
module io_gpio_filter import io_gpio_pkg::*; #(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int FILT_CYC    = FILT_CYC_DEF
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      pad_in,
  output logic      in_data,
  output edge_evt_t edge_evt
);

  localparam logic [FILT_W-1:0] CNT_MAX    = {FILT_W{1'b1}};
  localparam logic [FILT_W-1:0] CNT_ACCEPT = FILT_W'(FILT_CYC - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("io_gpio_filter: SYNC_STAGES must be at least 2");
  end
  if ((FILT_CYC < 1) || (FILT_CYC > (2 ** FILT_W) - 1)) begin : g_bad_filt
    $error("io_gpio_filter: FILT_CYC must lie in 1..2^FILT_W-1");
  end

  logic [SYNC_STAGES-1:0] sync_r;
  logic [FILT_W-1:0]      cnt_r;
  logic                   in_data_r;
  edge_evt_t              edge_r;
  logic                   s_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Metastability chain for the asynchronous pad input
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pad_in};
    end
  end

  // Debounce: a new level is accepted only after it has held for FILT_CYC synced cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r     <= {FILT_W{1'b0}};
      in_data_r <= 1'b0;
      edge_r    <= {EDGE_W{1'b0}};
    end else begin
      edge_r <= {EDGE_W{1'b0}};
      if (s_s == in_data_r) begin
        cnt_r <= {FILT_W{1'b0}};
      end else if (cnt_r >= CNT_ACCEPT) begin
        in_data_r         <= s_s;
        cnt_r             <= {FILT_W{1'b0}};
        edge_r[EDGE_RISE] <= s_s;
        edge_r[EDGE_FALL] <= ~s_s;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + FILT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign in_data  = in_data_r;
  assign edge_evt = edge_r;

endmodule

// File: rtl/io_gpio_bank.sv
// GPIO bank between the register block and the 3.3V pad ring: registered pad drive,
// filtered inputs and sticky edge interrupts. Optional self-test via IO_GPIO_BANK_LOOPBACK_EN.
module io_gpio_bank import io_gpio_pkg::*; #(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int FILT_CYC    = FILT_CYC_DEF
) (
  input  logic            clk,
  input  logic            resetn,
`ifdef IO_GPIO_BANK_LOOPBACK_EN
  input  logic            loopback,
`endif
  output logic [N_CH-1:0] pad_a,
  output logic [N_CH-1:0] pad_en_n,
  input  logic [N_CH-1:0] pad_y,
  io_gpio_bank_if.slave   bus
);

  logic [N_CH-1:0] pad_a_r;
  logic [N_CH-1:0] pad_en_n_r;
  logic [N_CH-1:0] pending_r;
  logic            irq_r;
  logic [N_CH-1:0] sync_in_s;
  logic [N_CH-1:0] in_data_s;
  logic [N_CH-1:0] rise_s;
  logic [N_CH-1:0] fall_s;
  logic [N_CH-1:0] set_s;

`ifdef IO_GPIO_BANK_LOOPBACK_EN
  // Loopback feeds the registered drive value back into the input path
  always_comb begin
    sync_in_s = pad_y;
    if (loopback) begin
      sync_in_s = pad_a_r;
    end else begin
      sync_in_s = pad_y;
    end
  end

  // Data and enable update together; loopback keeps every pad tristated
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pad_a_r    <= {N_CH{1'b0}};
      pad_en_n_r <= {N_CH{1'b1}};
    end else begin
      pad_a_r    <= bus.out_data;
      pad_en_n_r <= loopback ? {N_CH{1'b1}} : ~bus.out_en;
    end
  end
`else
  // Input path always sees the pad receiver
  always_comb begin
    sync_in_s = pad_y;
  end

  // Data and enable update together so a channel never glitches between them
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pad_a_r    <= {N_CH{1'b0}};
      pad_en_n_r <= {N_CH{1'b1}};
    end else begin
      pad_a_r    <= bus.out_data;
      pad_en_n_r <= ~bus.out_en;
    end
  end
`endif

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    edge_evt_t edge_s;

    io_gpio_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .FILT_CYC    (FILT_CYC)
    ) u_filter (
      .clk      (clk),
      .resetn   (resetn),
      .pad_in   (sync_in_s[ch]),
      .in_data  (in_data_s[ch]),
      .edge_evt (edge_s)
    );

    assign rise_s[ch] = edge_s[EDGE_RISE];
    assign fall_s[ch] = edge_s[EDGE_FALL];
  end

  // Qualify edge pulses with the per-channel enables sampled on the same cycle
  always_comb begin
    set_s = (rise_s & bus.irq_rise_en) | (fall_s & bus.irq_fall_en);
  end

  // Sticky pending bits: a new event outranks a simultaneous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_r <= {N_CH{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~bus.irq_clear) | set_s;
      irq_r     <= |pending_r;
    end
  end

  assign pad_a           = pad_a_r;
  assign pad_en_n        = pad_en_n_r;
  assign bus.in_data     = in_data_s;
  assign bus.irq_pending = pending_r;
  assign bus.irq         = irq_r;

endmodule

// File: tb/tb_io_gpio_bank.sv
// Directed bench for io_gpio_bank: expected values queued as stimulus is applied,
// popped and compared when the outputs are sampled on the falling clock edge.
module tb_io_gpio_bank;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] pad_a;
  logic [N-1:0] pad_en_n;
  logic [N-1:0] pad_y;
`ifdef IO_GPIO_BANK_LOOPBACK_EN
  logic         loopback;
`endif

  io_gpio_bank_if #(.N_CH(N)) bus_if ();

  io_gpio_bank #(
    .N_CH        (N),
    .SYNC_STAGES (2),
    .FILT_W      (4),
    .FILT_CYC    (8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
`ifdef IO_GPIO_BANK_LOOPBACK_EN
    .loopback (loopback),
`endif
    .pad_a    (pad_a),
    .pad_en_n (pad_en_n),
    .pad_y    (pad_y),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [N-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic expect_v(input string tag, input logic [N-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check_v(input logic [N-1:0] obs);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_miss++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [N-1:0] irq_vec();
    return {{(N-1){1'b0}}, bus_if.irq};
  endfunction

  initial begin
    logic [N-1:0] seen;

    resetn             = 1'b0;
    pad_y              = 16'h0000;
    bus_if.out_data    = 16'h0000;
    bus_if.out_en      = 16'h0000;
    bus_if.irq_rise_en = 16'h0000;
    bus_if.irq_fall_en = 16'h0000;
    bus_if.irq_clear   = 16'h0000;
`ifdef IO_GPIO_BANK_LOOPBACK_EN
    loopback           = 1'b0;
`endif
    cyc(2);
    resetn = 1'b1;

    // Output path: one cycle latency, data and enable together
    bus_if.out_en   = 16'h00FF;
    bus_if.out_data = 16'hA5A5;
    expect_v("out_pad_en_n", 16'hFF00);
    expect_v("out_pad_a",    16'hA5A5);
    cyc(1);
    check_v(pad_en_n);
    check_v(pad_a);

    // Traffic on every channel: in_data at +10, pending at +11, irq at +12
    bus_if.irq_rise_en = 16'hFFFF;
    pad_y              = 16'hFFFF;
    expect_v("traffic_in_data", 16'hFFFF);
    expect_v("traffic_pending", 16'hFFFF);
    expect_v("traffic_irq",     16'h0001);
    cyc(12);
    check_v(bus_if.in_data);
    check_v(bus_if.irq_pending);
    check_v(irq_vec());

    // Asynchronous reset mid-cycle must clear everything at once
    #2;
    resetn = 1'b0;
    #1;
    expect_v("rst_pad_en_n", 16'hFFFF);
    expect_v("rst_pad_a",    16'h0000);
    expect_v("rst_in_data",  16'h0000);
    expect_v("rst_pending",  16'h0000);
    expect_v("rst_irq",      16'h0000);
    check_v(pad_en_n);
    check_v(pad_a);
    check_v(bus_if.in_data);
    check_v(bus_if.irq_pending);
    check_v(irq_vec());
    pad_y              = 16'h0000;
    bus_if.out_en      = 16'h0000;
    bus_if.out_data    = 16'h0000;
    cyc(2);
    resetn             = 1'b1;
    bus_if.irq_rise_en = 16'hFFFF;
    bus_if.irq_fall_en = 16'hFFFF;

    // Leaving reset must not manufacture an edge event
    expect_v("post_rst_pending", 16'h0000);
    expect_v("post_rst_irq",     16'h0000);
    cyc(12);
    check_v(bus_if.irq_pending);
    check_v(irq_vec());

    // Short pulse on ch3 is discarded by the filter
    bus_if.irq_rise_en = 16'h0008;
    bus_if.irq_fall_en = 16'h0000;
    pad_y = 16'h0008;
    cyc(5);
    pad_y = 16'h0000;
    seen  = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      seen = seen | bus_if.in_data;
    end
    expect_v("short_pulse_in_data", 16'h0000);
    expect_v("short_pulse_pending", 16'h0000);
    check_v(seen);
    check_v(bus_if.irq_pending);

    // Stable rise on ch3: cycle-exact latency of in_data, pending and irq
    pad_y = 16'h0008;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      expect_v($sformatf("rise_in_data_c%0d", k), (k >= 10) ? 16'h0008 : 16'h0000);
      expect_v($sformatf("rise_pending_c%0d", k), (k >= 11) ? 16'h0008 : 16'h0000);
      expect_v($sformatf("rise_irq_c%0d", k),     (k >= 12) ? 16'h0001 : 16'h0000);
      check_v(bus_if.in_data);
      check_v(bus_if.irq_pending);
      check_v(irq_vec());
    end

    // Fall with irq_fall_en=0 leaves pending unchanged
    pad_y = 16'h0000;
    expect_v("fall_in_data", 16'h0000);
    expect_v("fall_pending", 16'h0008);
    cyc(14);
    check_v(bus_if.in_data);
    check_v(bus_if.irq_pending);

    // Clear alone: pending drops next edge, irq one edge later
    bus_if.irq_clear = 16'h0008;
    cyc(1);
    bus_if.irq_clear = 16'h0000;
    expect_v("clr_pending",  16'h0000);
    expect_v("clr_irq_hold", 16'h0001);
    check_v(bus_if.irq_pending);
    check_v(irq_vec());
    expect_v("clr_irq_drop", 16'h0000);
    cyc(1);
    check_v(irq_vec());

    // Clear coinciding with a new rise event: set wins
    pad_y = 16'h0008;
    cyc(10);
    bus_if.irq_clear = 16'h0008;
    cyc(1);
    bus_if.irq_clear = 16'h0000;
    expect_v("race_pending", 16'h0008);
    check_v(bus_if.irq_pending);
    expect_v("race_pending_hold", 16'h0008);
    expect_v("race_irq",          16'h0001);
    cyc(1);
    check_v(bus_if.irq_pending);
    check_v(irq_vec());

    // Disabling the enable does not clear the sticky bit
    bus_if.irq_rise_en = 16'h0000;
    expect_v("disable_keeps_pending", 16'h0008);
    cyc(2);
    check_v(bus_if.irq_pending);

`ifdef IO_GPIO_BANK_LOOPBACK_EN
    // Loopback: pads tristated, driven value returns through the filter at +11
    pad_y           = 16'h0000;
    bus_if.out_data = 16'h0000;
    bus_if.out_en   = 16'h0000;
    cyc(14);
    loopback        = 1'b1;
    bus_if.out_data = 16'h0001;
    bus_if.out_en   = 16'h0001;
    expect_v("lb_pad_en_n", 16'hFFFF);
    expect_v("lb_pad_a",    16'h0001);
    cyc(1);
    check_v(pad_en_n);
    check_v(pad_a);
    expect_v("lb_in_data_c10", 16'h0000);
    cyc(9);
    check_v(bus_if.in_data);
    expect_v("lb_in_data_c11", 16'h0001);
    cyc(1);
    check_v(bus_if.in_data);
`endif

    if (exp_q.size() != 0) begin
      n_miss++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/io_gpio_bank.md
Name: io_gpio_bank

Overview:
- Parametrised, clocked GPIO bank that drives N io_bidirectional_3v3 / io_input_3v3 pad pairs from core logic.
- Adds what the bare pad cells lack:
  - registered output/enable
  - input synchroniser
  - per-channel debounce filter
  - per-channel edge-detect interrupt with sticky pending bits
- Sits between the SoC GPIO register block and the 3.3V pad ring.

Parameters:
- N_CH, 16, number of channels.
- SYNC_STAGES, 2, input synchroniser flops (minimum 2).
- FILT_W, 4, debounce counter width.
- FILT_CYC, 8, consecutive stable cycles required to accept a new level (1..2^FILT_W-1).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- out_data  input  N_CH  value to drive per channel.
- out_en  input  N_CH  1 = drive pad, 0 = tristate.
- pad_a  output  N_CH  to pad cell A.
- pad_en_n  output  N_CH  to pad cell EN (active-low enable: 0 drives).
- pad_y  input  N_CH  from input cell Y (asynchronous).
- in_data  output  N_CH  synchronised, debounced input level.
- irq_rise_en  input  N_CH  enable rising-edge capture.
- irq_fall_en  input  N_CH  enable falling-edge capture.
- irq_clear  input  N_CH  write-1-to-clear pulse for pending bits.
- irq_pending  output  N_CH  sticky edge flags.
- irq  output  1  OR of irq_pending.

Behaviour:
- Reset (async assert, synchronous deassert is the integrator's job):
  - pad_a=0, pad_en_n=all 1 (all pads tristated).
  - sync flops=0, in_data=0, counters=0, irq_pending=0, irq=0.
- Output path:
  - pad_a <= out_data and pad_en_n <= ~out_en, one cycle latency.
  - Both bits of a channel update in the same cycle, so there is no glitch between data and enable.
- Input path, per channel:
  - pad_y passes through SYNC_STAGES flops giving s.
  - If s == in_data: counter clears to 0.
  - Else: counter increments, saturating at 2^FILT_W-1.
  - When the counter reaches FILT_CYC-1 with s still != in_data, in_data <= s and the counter clears.
  - A stable change therefore appears on in_data SYNC_STAGES+FILT_CYC cycles after the pad edge.
  - A pulse shorter than FILT_CYC synced cycles is discarded.
  - FILT_CYC=1 gives a pure synchroniser plus one register.
- Edge detect:
  - Rise event = in_data 0->1 with irq_rise_en=1.
  - Fall event = in_data 1->0 with irq_fall_en=1.
  - An event sets irq_pending on the cycle after the in_data change.
  - irq_clear bit clears pending on the next edge.
  - Set and clear in the same cycle: set wins, the bit stays 1.
  - Disabling rise/fall enables does not clear pending bits.
- irq = |irq_pending, registered, one cycle after pending.
- Changing out_en has no effect on the input path; a driven pad reads back its own value through the filter.
- Reset mid-filter: counter and in_data return to 0; no edge event is generated by reset.
- Counter width rule: the FILT_CYC > 2^FILT_W-1 configuration is illegal; compile-time assertion.

Optional Feature:
- Macro: IO_GPIO_BANK_LOOPBACK_EN
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the synchroniser input for each channel is pad_a (the registered output) instead of pad_y.
  - pad_en_n is forced to all 1 (pads tristated) while loopback=1, for self-test without external drive.
  - Switching loopback takes effect at the synchroniser input immediately; the filter hides transients shorter than FILT_CYC.
- Undefined: no loopback port; the input path always uses pad_y.

Decomposition:
- Package io_gpio_pkg:
  - default N_CH / SYNC_STAGES / FILT_W / FILT_CYC constants
  - edge-select encoding constants (EDGE_RISE, EDGE_FALL)
- Sub-module io_gpio_filter:
  - single channel: synchroniser chain, debounce counter, in_data register, edge-event outputs
  - instantiated N_CH times in a generate loop
- Top holds the output registers and the pending/irq logic.

Test Plan:
- Reset: assert resetn=0 mid-traffic -> pad_en_n=16'hFFFF, pad_a=0, in_data=0, irq_pending=0, irq=0 immediately.
- Output: out_en=16'h00FF, out_data=16'hA5A5 -> next cycle pad_en_n=16'hFF00, pad_a=16'hA5A5.
- Debounce:
  - pad_y[3] high for 5 cycles then low -> in_data[3] stays 0.
  - pad_y[3] high for 20 cycles -> in_data[3] rises exactly 10 cycles after the pad edge (2 sync + 8 filter).
- Edge irq: irq_rise_en[3]=1, stable rise on ch3 -> irq_pending=16'h0008 one cycle after in_data[3] rises, irq=1 the cycle after. Fall with irq_fall_en=0 -> no new pending.
- Clear race: pulse irq_clear[3] in the same cycle as a new rise event on ch3 -> irq_pending[3] stays 1. Clear alone -> 0 next cycle, irq drops one cycle later.
- Loopback (macro defined): loopback=1, out_data[0]=1, out_en[0]=1 -> pad_en_n[0]=1, in_data[0]=1 after 1+2+8 cycles.
